// File: rtl/led_mode_pkg.sv
// ============================================================================
// Module      : led_mode_pkg
// Description : Shared LED mode state encoding, parameter defaults and the
//               mode-advance / LED-map helpers for led_mode_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_mode_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_RED   = 3'd1,
    ST_GREEN = 3'd2,
    ST_ALT   = 3'd3,
    ST_BLINK = 3'd4
  } state_t;

  localparam int c_deb_cycles_def = 500000;
  localparam int c_blink_half_def = 12500000;
  localparam int c_idle_ticks_def = 40;

  function automatic state_t next_mode(input state_t s);
    case (s)
      ST_OFF:   return ST_RED;
      ST_RED:   return ST_GREEN;
      ST_GREEN: return ST_ALT;
      ST_ALT:   return ST_BLINK;
      default:  return ST_OFF;
    endcase
  endfunction

  // Returns {red, green}.
  function automatic logic [1:0] led_map(input state_t s, input logic phase);
    case (s)
      ST_RED:   return 2'b10;
      ST_GREEN: return 2'b01;
      ST_ALT:   return {phase, ~phase};
      ST_BLINK: return {phase, phase};
      default:  return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// Module      : sw_debounce
// Description : Two-flop synchronizer, level debouncer and rising-edge
//               detector producing a single-cycle press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce
  import led_mode_pkg::*;
#(
  parameter int DEB_CYCLES = c_deb_cycles_def
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_deb_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      // The new level is taken on the DEB_CYCLES-th consecutive disagreeing cycle.
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_deb & ~r_deb_d;

endmodule

`default_nettype wire

// File: rtl/led_mode_ctrl.sv
// ============================================================================
// Module      : led_mode_ctrl
// Description : Push-button LED mode sequencer (OFF/RED/GREEN/ALT/BLINK) with
//               blink generator; optional idle timeout to OFF when the macro
//               LED_MODE_CTRL_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_mode_ctrl
  import led_mode_pkg::*;
#(
  parameter int DEB_CYCLES = c_deb_cycles_def,
  parameter int BLINK_HALF = c_blink_half_def,
  parameter int IDLE_TICKS = c_idle_ticks_def
) (
  input  logic CLK,
  input  logic NRST,
  input  logic SW,
  output logic LED_ROUGE,
  output logic LED_VERTE
);

  localparam int BLK_W = $clog2(BLINK_HALF);
  localparam logic [BLK_W-1:0] c_blk_last = BLK_W'(BLINK_HALF - 1);

  if (DEB_CYCLES < 2 || BLINK_HALF < 2 || IDLE_TICKS < 2) begin : g_param_chk
    $error("led_mode_ctrl: DEB_CYCLES, BLINK_HALF and IDLE_TICKS must be >= 2");
  end

  logic             w_press;
  logic             w_tick;
  logic             w_timeout;
  logic             w_state_chg;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_phase;
  logic             r_led_r;
  logic             r_led_g;

  sw_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_sw_debounce (
    .clk    (CLK),
    .rst_n  (NRST),
    .i_sw   (SW),
    .o_press(w_press)
  );

  assign w_tick = (r_blk_cnt == c_blk_last);

`ifdef LED_MODE_CTRL_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_TICKS);
  localparam logic [IDLE_W-1:0] c_idle_last = IDLE_W'(IDLE_TICKS - 1);

  logic [IDLE_W-1:0] r_idle_cnt;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_idle_cnt <= '0;
    end else if (w_state_chg || (r_state == ST_OFF)) begin
      r_idle_cnt <= '0;
    end else if (w_tick) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state != ST_OFF) && w_tick && (r_idle_cnt == c_idle_last);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A press always wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_state_chg = 1'b0;
    if (w_press) begin
      w_state_nxt = next_mode(r_state);
    end else if (w_timeout) begin
      w_state_nxt = ST_OFF;
    end
    w_state_chg = (w_state_nxt != r_state);
  end

  // A state change restarts the blink period; any coincident tick is dropped.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (w_state_chg) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (w_tick) begin
      r_blk_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_led_r <= 1'b0;
      r_led_g <= 1'b0;
    end else begin
      {r_led_r, r_led_g} <= led_map(r_state, r_phase);
    end
  end

  assign LED_ROUGE = r_led_r;
  assign LED_VERTE = r_led_g;

endmodule

`default_nettype wire
